// File: rtl/williams_display_engine_if.sv
// Store-write and ACC-load port of the Williams display engine.
interface williams_display_engine_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned AW     = 5
);
    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              acc_valid;
    logic [WORD_W-1:0] acc_data;

    modport master (
        output wr_valid, wr_addr, wr_data, acc_valid, acc_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, acc_valid, acc_data,
        output wr_ready
    );
endinterface

// File: rtl/williams_display_engine.sv
// Williams-tube raster renderer: shadow store + ACC drawn as a dot matrix,
// with a reset-time clear sequencer, same-row write bypass and CI-row blink highlight.
module williams_display_engine #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned CELL_LOG2  = 4,
    parameter int unsigned ORG_X      = 4,
    parameter int unsigned ORG_Y      = 1,
    parameter int unsigned COLOR_W    = 10,
    parameter int unsigned FETCH_X    = 800,
    parameter int unsigned BLINK_LOG2 = 5
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     candraw,
    input  logic [10:0]              x,
    input  logic [10:0]              y,
    input  logic                     frame_tick,
    output logic [COLOR_W-1:0]       red,
    output logic [COLOR_W-1:0]       green,
    output logic [COLOR_W-1:0]       blue,
    output logic                     n_vga_blank,
    williams_display_engine_if.slave bus,
    input  logic [$clog2(DEPTH)-1:0] ci,
    input  logic                     hl_en
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned BW    = $clog2(WORD_W);
    localparam int unsigned CELL  = 1 << CELL_LOG2;
    localparam int unsigned MAXC  = (1 << COLOR_W) - 1;
    localparam int unsigned DIM_I = (400 > MAXC) ? MAXC : 400;
    localparam logic [COLOR_W-1:0] BRIGHT = '1;
    localparam logic [COLOR_W-1:0] DIM    = COLOR_W'(DIM_I);
    localparam logic [10:0] X0   = 11'(ORG_X);
    localparam logic [10:0] X1   = 11'(ORG_X + WORD_W);
    localparam logic [10:0] Y0   = 11'(ORG_Y);
    localparam logic [10:0] Y1   = 11'(ORG_Y + DEPTH);
    localparam logic [10:0] YACC = 11'(ORG_Y + DEPTH + 1);
    localparam logic [10:0] FX   = 11'(FETCH_X);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              state, state_nx;
    logic [AW-1:0]       clr_addr;
    logic                clearing;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   acc, line_buf;
    logic [AW-1:0]       line_row;
    logic [BLINK_LOG2:0] blink;
    logic                fetch, accept;
    logic [AW-1:0]       fetch_idx;
    logic [10:0]         cx, cy;
    logic [BW-1:0]       bidx;
    int unsigned         oxi, oyi;
    logic                on_dot, off_dot, in_store, in_acc, bit_v, hl;
    logic [COLOR_W-1:0]  level;

    assign cx        = x >> CELL_LOG2;
    assign cy        = y >> CELL_LOG2;
    assign oxi       = 32'(x[CELL_LOG2-1:0]);
    assign oyi       = 32'(y[CELL_LOG2-1:0]);
    assign fetch     = (state == S_RUN) && (x == FX) && (&y[CELL_LOG2-1:0]);
    // The line fetched at the bottom of cell row cy is the one shown on row cy+1.
    assign fetch_idx = AW'(cy + 11'd1 - Y0);
    assign accept    = bus.wr_valid && bus.wr_ready;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clearing ? clr_addr + AW'(1) : '0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_CLEAR: if (clr_addr == AW'(DEPTH - 1)) state_nx = S_RUN;
            S_RUN:   state_nx = S_RUN;
            default: state_nx = S_CLEAR;
        endcase
    end

    always_comb begin
        clearing     = (state == S_CLEAR);
        bus.wr_ready = (state == S_RUN) && !fetch;
    end

    always_ff @(posedge clk) begin
        if (clearing)
            mem[clr_addr] <= '0;
        else if (accept)
            mem[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            line_buf <= '0;
            line_row <= '0;
            acc      <= '0;
            blink    <= '0;
        end else begin
            if (fetch) begin
                line_buf <= mem[fetch_idx];
                line_row <= fetch_idx;
            end else if (accept && (bus.wr_addr == line_row)) begin
                line_buf <= bus.wr_data;
            end
            if (bus.acc_valid) acc <= bus.acc_data;
            if (frame_tick) blink <= blink + 1'b1;
        end
    end

    assign on_dot   = (oxi >= CELL/4) && (oxi <= 3*CELL/4 - 1) &&
                      (oyi >= CELL/4) && (oyi <= 3*CELL/4 - 1);
    assign off_dot  = (oxi >= 3*CELL/8) && (oxi <= 5*CELL/8 - 1) &&
                      (oyi >= 3*CELL/8) && (oyi <= 5*CELL/8 - 1);
    assign in_store = (cx >= X0) && (cx < X1) && (cy >= Y0) && (cy < Y1);
    assign in_acc   = (cx >= X0) && (cx < X1) && (cy == YACC);
    assign bidx     = BW'(cx - X0);
    assign hl       = in_store && hl_en && (line_row == ci) && blink[BLINK_LOG2];

    always_comb begin
        level = '0;
        bit_v = in_store ? line_buf[bidx] : acc[bidx];
        if (in_store || in_acc) begin
            if (bit_v && on_dot)
                level = BRIGHT;
            else if (off_dot)
                level = DIM;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            n_vga_blank <= 1'b0;
        end else if (!candraw) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            n_vga_blank <= 1'b0;
        end else begin
            red         <= hl ? level : '0;
            green       <= hl ? '0 : level;
            blue        <= '0;
            n_vga_blank <= 1'b1;
        end
    end
endmodule

// File: tb/tb_williams_display_engine.sv
// Directed self-checking bench for williams_display_engine.
module tb_williams_display_engine;
    logic        clk;
    logic        n_reset;
    logic        candraw;
    logic [10:0] x, y;
    logic        frame_tick;
    logic [9:0]  red, green, blue;
    logic        n_vga_blank;
    logic [4:0]  ci;
    logic        hl_en;
    int          total = 0;
    int          bad = 0;

    williams_display_engine_if #(.WORD_W(32), .AW(5)) bus ();

    williams_display_engine #(
        .WORD_W(32), .DEPTH(32), .CELL_LOG2(4), .ORG_X(4), .ORG_Y(1),
        .COLOR_W(10), .FETCH_X(800), .BLINK_LOG2(5)
    ) dut (
        .clk(clk), .n_reset(n_reset), .candraw(candraw), .x(x), .y(y),
        .frame_tick(frame_tick), .red(red), .green(green), .blue(blue),
        .n_vga_blank(n_vga_blank), .bus(bus), .ci(ci), .hl_en(hl_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int px, input int py);
        x = 11'(px);
        y = 11'(py);
        candraw = 1'b1;
        step();
    endtask

    task automatic fetch(input int py);
        x = 11'd800;
        y = 11'(py);
        candraw = 1'b0;
        step();
        x = '0;
        y = '0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        int n;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'(a);
        bus.wr_data  = d;
        #1;
        n = 0;
        while (bus.wr_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        total++;
        if (bus.wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_accept_timeout: wr_ready=%b want 1", bus.wr_ready);
        end
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic count_clear(input string name);
        int zeros;
        zeros = 0;
        while (bus.wr_ready !== 1'b1 && zeros < 100) begin
            zeros++;
            step();
        end
        total++;
        if (zeros !== 32) begin
            bad++;
            $display("FAIL %s_clear_len: got %0d cycles want 32", name, zeros);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        x = 11'd72; y = 11'd24; candraw = 1'b1;
        repeat (3) step();
        total++;
        if ({red, green, blue} !== 30'd0 || n_vga_blank !== 1'b0 || bus.wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: rgb=%h blank=%b ready=%b want 0/0/0",
                     {red, green, blue}, n_vga_blank, bus.wr_ready);
        end
        x = '0; y = '0; candraw = 1'b0;
        n_reset = 1'b1;
        count_clear("reset");
        pix(72, 24);
        total++;
        if (green !== 10'd400 || red !== 10'd0) begin
            bad++;
            $display("FAIL first_frame_offdot: green=%0d red=%0d want 400/0", green, red);
        end
        pix(68, 24);
        total++;
        if (green !== 10'd0) begin
            bad++;
            $display("FAIL first_frame_ondot_only: green=%0d want 0", green);
        end
        pix(72, 20);
        total++;
        if (green !== 10'd0) begin
            bad++;
            $display("FAIL first_frame_oy4: green=%0d want 0", green);
        end
    endtask

    task automatic test_write_bit();
        wr(0, 32'h0000_0001);
        fetch(15);
        pix(72, 24);
        total++;
        if (green !== 10'd1023 || red !== 10'd0) begin
            bad++;
            $display("FAIL bit0_bright: green=%0d red=%0d want 1023/0", green, red);
        end
        pix(88, 24);
        total++;
        if (green !== 10'd400) begin
            bad++;
            $display("FAIL bit1_dim: green=%0d want 400", green);
        end
        pix(80, 24);
        total++;
        if (green !== 10'd0) begin
            bad++;
            $display("FAIL cell_edge_black: green=%0d want 0", green);
        end
    endtask

    task automatic test_fetch_stall();
        x = 11'd800; y = 11'd15; candraw = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd5;
        bus.wr_data  = 32'hA5A5_0003;
        #1;
        total++;
        if (bus.wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready: got %b want 0", bus.wr_ready);
        end
        step();
        x = '0; y = '0;
        #1;
        total++;
        if (bus.wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: got %b want 1", bus.wr_ready);
        end
        step();
        bus.wr_valid = 1'b0;
        fetch(95);
        pix(72, 104);
        total++;
        if (green !== 10'd1023) begin
            bad++;
            $display("FAIL stall_data_bit0: green=%0d want 1023", green);
        end
        pix(104, 104);
        total++;
        if (green !== 10'd400) begin
            bad++;
            $display("FAIL stall_data_bit2: green=%0d want 400", green);
        end
        pix(568, 104);
        total++;
        if (green !== 10'd1023) begin
            bad++;
            $display("FAIL stall_data_bit31: green=%0d want 1023", green);
        end
    endtask

    task automatic test_bypass();
        fetch(47);
        pix(136, 56);
        total++;
        if (green !== 10'd400) begin
            bad++;
            $display("FAIL bypass_before: green=%0d want 400", green);
        end
        x = 11'd136; y = 11'd50; candraw = 1'b1;
        wr(2, 32'hFFFF_FFFF);
        pix(136, 50);
        total++;
        if (green !== 10'd0) begin
            bad++;
            $display("FAIL bypass_oy2_black: green=%0d want 0", green);
        end
        pix(136, 56);
        total++;
        if (green !== 10'd1023) begin
            bad++;
            $display("FAIL bypass_after: green=%0d want 1023", green);
        end
    endtask

    task automatic test_blink();
        wr(3, 32'h0000_0001);
        fetch(63);
        hl_en = 1'b1;
        ci = 5'd3;
        pix(72, 72);
        total++;
        if (green !== 10'd1023 || red !== 10'd0) begin
            bad++;
            $display("FAIL blink_f0: green=%0d red=%0d want 1023/0", green, red);
        end
        ticks(31);
        pix(72, 72);
        total++;
        if (green !== 10'd1023 || red !== 10'd0) begin
            bad++;
            $display("FAIL blink_f31: green=%0d red=%0d want 1023/0", green, red);
        end
        ticks(1);
        pix(72, 72);
        total++;
        if (red !== 10'd1023 || green !== 10'd0) begin
            bad++;
            $display("FAIL blink_f32: red=%0d green=%0d want 1023/0", red, green);
        end
        pix(88, 72);
        total++;
        if (red !== 10'd400 || green !== 10'd0) begin
            bad++;
            $display("FAIL blink_dim_red: red=%0d green=%0d want 400/0", red, green);
        end
        ci = 5'd4;
        pix(72, 72);
        total++;
        if (green !== 10'd1023 || red !== 10'd0) begin
            bad++;
            $display("FAIL blink_ci_other: green=%0d red=%0d want 1023/0", green, red);
        end
        ci = 5'd3;
        ticks(31);
        pix(72, 72);
        total++;
        if (red !== 10'd1023 || green !== 10'd0) begin
            bad++;
            $display("FAIL blink_f63: red=%0d green=%0d want 1023/0", red, green);
        end
        ticks(1);
        pix(72, 72);
        total++;
        if (green !== 10'd1023 || red !== 10'd0) begin
            bad++;
            $display("FAIL blink_f64: green=%0d red=%0d want 1023/0", green, red);
        end
        hl_en = 1'b0;
    endtask

    task automatic test_acc();
        pix(568, 552);
        total++;
        if (green !== 10'd400) begin
            bad++;
            $display("FAIL acc_before: green=%0d want 400", green);
        end
        bus.acc_valid = 1'b1;
        bus.acc_data  = 32'h8000_0000;
        step();
        bus.acc_valid = 1'b0;
        pix(568, 552);
        total++;
        if (green !== 10'd1023 || red !== 10'd0 || n_vga_blank !== 1'b1) begin
            bad++;
            $display("FAIL acc_bit31: green=%0d red=%0d blank=%b want 1023/0/1",
                     green, red, n_vga_blank);
        end
        pix(552, 552);
        total++;
        if (green !== 10'd400) begin
            bad++;
            $display("FAIL acc_bit30: green=%0d want 400", green);
        end
        candraw = 1'b0;
        step();
        total++;
        if (n_vga_blank !== 1'b0 || {red, green, blue} !== 30'd0) begin
            bad++;
            $display("FAIL blanking: blank=%b rgb=%h want 0/0", n_vga_blank, {red, green, blue});
        end
    endtask

    task automatic test_reset_restart();
        n_reset = 1'b0;
        #2;
        total++;
        if (bus.wr_ready !== 1'b0 || n_vga_blank !== 1'b0) begin
            bad++;
            $display("FAIL restart_async: ready=%b blank=%b want 0/0", bus.wr_ready, n_vga_blank);
        end
        step();
        x = '0; y = '0; candraw = 1'b0;
        n_reset = 1'b1;
        count_clear("restart");
        pix(568, 552);
        total++;
        if (green !== 10'd400) begin
            bad++;
            $display("FAIL restart_acc_cleared: green=%0d want 400", green);
        end
        fetch(95);
        pix(72, 104);
        total++;
        if (green !== 10'd400) begin
            bad++;
            $display("FAIL restart_store_cleared: green=%0d want 400", green);
        end
    endtask

    initial begin
        n_reset       = 1'b0;
        candraw       = 1'b0;
        x             = '0;
        y             = '0;
        frame_tick    = 1'b0;
        ci            = '0;
        hl_en         = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.acc_valid = 1'b0;
        bus.acc_data  = '0;
        test_reset();
        test_write_bit();
        test_fetch_stall();
        test_bypass();
        test_blink();
        test_acc();
        test_reset_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
